// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 key event decoder: strips E0/F0/E1 prefixes from the receiver byte
// stream, queues one {extended, break, code} event per keystroke, tracks shift.
module ps2_key_event_decoder #(
  parameter int DEPTH      = 4,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic [7:0] scancode,
  input  logic       scan_ready,
  input  logic       rd_en,
  output logic       event_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_extended,
  output logic       shift_held,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (PAUSE_SKIP > 0) ? $clog2(PAUSE_SKIP + 1) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

  function automatic logic is_ctrl(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return b inside {8'hE0, 8'hF0, 8'hE1};
  endfunction

  state_t          state_q, state_nxt;
  logic [SW-1:0]   skip_cnt;
  logic            emit_p0;
  logic [9:0]      entry_p0;
  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [AW:0]     count, count_nxt;
  logic            pop, push;
  logic [9:0]      head_p1, head_nxt;
  logic            shift_l, shift_r;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (scan_ready) begin
      if (state_q == S_SKIP) begin
        if (skip_cnt <= SW'(1)) state_nxt = S_IDLE;
      end else if (is_ctrl(scancode)) begin
        state_nxt = S_IDLE;
      end else begin
        unique case (scancode)
          8'hE0:   state_nxt = (state_q == S_BRK || state_q == S_EXT_BRK) ? S_EXT_BRK : S_EXT;
          8'hF0:   state_nxt = (state_q == S_EXT || state_q == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
          8'hE1:   state_nxt = S_SKIP;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    emit_p0  = scan_ready && (state_q != S_SKIP) && !is_ctrl(scancode) && !is_prefix(scancode);
    entry_p0 = {(state_q == S_EXT || state_q == S_EXT_BRK),
                (state_q == S_BRK || state_q == S_EXT_BRK), scancode};
  end

  // Pause sequence: count the remaining bytes blind, control bytes included
  always_ff @(posedge CLK50MHZ) begin
    if (RST) skip_cnt <= '0;
    else if (scan_ready) begin
      if (state_q == S_SKIP)        skip_cnt <= (skip_cnt == '0) ? '0 : skip_cnt - SW'(1);
      else if (state_nxt == S_SKIP) skip_cnt <= SW'(PAUSE_SKIP);
    end
  end

  always_comb begin
    pop        = rd_en && (count != '0);
    push       = emit_p0 && ((count != DEPTH_C) || pop);
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (pop && !push) count_nxt = count - CNT_ONE;
    // Empty outputs keep the last popped entry; a push into an emptied queue bypasses mem
    head_nxt = head_p1;
    if (count_nxt != '0)
      head_nxt = (count == '0 || (count == CNT_ONE && pop)) ? entry_p0 : mem[rd_ptr_nxt];
  end

  always_ff @(posedge CLK50MHZ) begin
    if (push) mem[wr_ptr] <= entry_p0;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_p1  <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      head_p1 <= head_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (emit_p0 && !push) overflow <= 1'b1;
    end
  end

  // Shift tracking follows every decoded non-extended event, even if the queue dropped it
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (emit_p0 && !entry_p0[9]) begin
      if (scancode == 8'h12) shift_l <= !entry_p0[8];
      if (scancode == 8'h59) shift_r <= !entry_p0[8];
    end
  end

  assign event_valid  = (count != '0);
  assign key_extended = head_p1[9];
  assign key_break    = head_p1[8];
  assign key_code     = head_p1[7:0];
  assign shift_held   = shift_l || shift_r;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: an event-queue model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ps2_key_event_decoder;

  localparam int DEPTH      = 4;
  localparam int PAUSE_SKIP = 7;

  logic       CLK50MHZ = 1'b0;
  logic       RST;
  logic [7:0] scancode;
  logic       scan_ready;
  logic       rd_en;
  logic       event_valid;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_extended;
  logic       shift_held;
  logic       overflow;

  ps2_key_event_decoder #(.DEPTH(DEPTH), .PAUSE_SKIP(PAUSE_SKIP)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .scancode(scancode), .scan_ready(scan_ready),
    .rd_en(rd_en), .event_valid(event_valid), .key_code(key_code),
    .key_break(key_break), .key_extended(key_extended), .shift_held(shift_held),
    .overflow(overflow)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  int checks = 0;
  int errors = 0;

  // Model: pending events, prefix flags, pause bytes left, shift flags, sticky overflow
  logic [9:0] m_q[$];
  logic [9:0] m_last;
  logic       m_ext, m_brk, m_sl, m_sr, m_ovf, m_init;
  int         m_skip;

  task automatic model_step();
    logic [9:0] e;
    logic       do_pop, do_emit;
    if (RST) begin
      m_q.delete(); m_last = '0; m_ext = 0; m_brk = 0; m_skip = 0;
      m_sl = 0; m_sr = 0; m_ovf = 0; m_init = 1;
      return;
    end
    do_emit = 0;
    e = '0;
    if (scan_ready) begin
      if (m_skip > 0) m_skip--;
      else if (scancode inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
        m_ext = 0; m_brk = 0;
      end
      else if (scancode == 8'hE0) m_ext = 1;
      else if (scancode == 8'hF0) m_brk = 1;
      else if (scancode == 8'hE1) begin
        m_skip = PAUSE_SKIP; m_ext = 0; m_brk = 0;
      end else begin
        do_emit = 1;
        e = {m_ext, m_brk, scancode};
        m_ext = 0; m_brk = 0;
      end
    end
    do_pop = rd_en && (m_q.size() > 0);
    if (do_emit && !e[9]) begin
      if (e[7:0] == 8'h12) m_sl = !e[8];
      if (e[7:0] == 8'h59) m_sr = !e[8];
    end
    if (do_emit && m_q.size() == DEPTH && !do_pop) m_ovf = 1;
    if (do_pop) m_last = m_q.pop_front();
    if (do_emit && !(m_ovf && m_q.size() == DEPTH)) m_q.push_back(e);
  endtask

  // Compare the post-edge state, then step the model with the inputs the next edge will see
  initial begin
    logic [9:0] head;
    logic [12:0] exp_v, act_v;
    m_init = 0;
    forever begin
      @(negedge CLK50MHZ);
      if (m_init) begin
        head  = (m_q.size() > 0) ? m_q[0] : m_last;
        exp_v = {(m_q.size() > 0), head, (m_sl || m_sr), m_ovf};
        act_v = {event_valid, key_extended, key_break, key_code, shift_held, overflow};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_model t=%0t got vld=%b ext=%b brk=%b code=%h shift=%b ovf=%b want vld=%b ext=%b brk=%b code=%h shift=%b ovf=%b",
                   $time, act_v[12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                   exp_v[12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
        end
      end
      model_step();
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scancode = b; scan_ready = 1'b1;
    tick();
    scan_ready = 1'b0; scancode = 8'h00;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    RST = 1'b1; scancode = 8'h00; scan_ready = 1'b0; rd_en = 1'b0;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    repeat (3) tick();
    lit("rst_valid", {7'd0, event_valid}, 8'h00);
    lit("rst_code", key_code, 8'h00);
    lit("rst_shift", {7'd0, shift_held}, 8'h00);
    lit("rst_ovf", {7'd0, overflow}, 8'h00);
    RST = 1'b0;
    tick();

    // plain make, one-cycle latency, pop empties and holds head
    send(8'h1C);
    lit("make_valid", {7'd0, event_valid}, 8'h01);
    lit("make_code", key_code, 8'h1C);
    lit("make_flags", {6'd0, key_extended, key_break}, 8'h00);
    pop1();
    lit("pop_empty", {7'd0, event_valid}, 8'h00);
    lit("pop_hold_code", key_code, 8'h1C);

    send(8'hF0); send(8'h1C);
    lit("brk_code", key_code, 8'h1C);
    lit("brk_flags", {6'd0, key_extended, key_break}, 8'h01);
    pop1();
    send(8'hE0); send(8'hF0); send(8'h75);
    lit("extbrk_code", key_code, 8'h75);
    lit("extbrk_flags", {6'd0, key_extended, key_break}, 8'h03);
    pop1();
    send(8'hE0); send(8'hE0); send(8'h75);
    lit("ext2_flags", {6'd0, key_extended, key_break}, 8'h02);
    pop1();

    // pause sequence swallowed whole, then a normal make
    foreach (pause_seq[i]) send(pause_seq[i]);
    lit("pause_no_event", {7'd0, event_valid}, 8'h00);
    send(8'h1C);
    lit("after_pause_code", key_code, 8'h1C);
    lit("after_pause_flags", {6'd0, key_extended, key_break}, 8'h00);
    pop1();
    send(8'hAA); send(8'hFA); tick();
    lit("ctrl_no_event", {7'd0, event_valid}, 8'h00);

    // overflow on fifth push
    for (int k = 0; k < 5; k++) send(8'h15 + 8'(k));
    lit("ovf_set", {7'd0, overflow}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      lit("ovf_pop_order", key_code, 8'h15 + 8'(k));
      pop1();
    end
    lit("ovf_drained", {7'd0, event_valid}, 8'h00);
    lit("ovf_sticky", {7'd0, overflow}, 8'h01);

    // push with simultaneous pop while full
    for (int k = 0; k < 4; k++) send(8'h20 + 8'(k));
    scancode = 8'h1A; scan_ready = 1'b1; rd_en = 1'b1;
    tick();
    scan_ready = 1'b0; rd_en = 1'b0; scancode = 8'h00;
    for (int k = 0; k < 3; k++) begin
      lit("full_pp_order", key_code, 8'h21 + 8'(k));
      pop1();
    end
    lit("full_pp_last", key_code, 8'h1A);
    lit("full_pp_valid", {7'd0, event_valid}, 8'h01);
    pop1();
    lit("full_pp_empty", {7'd0, event_valid}, 8'h00);

    // empty with simultaneous push and pop request: push lands
    scancode = 8'h33; scan_ready = 1'b1; rd_en = 1'b1;
    tick();
    scan_ready = 1'b0; rd_en = 1'b0; scancode = 8'h00;
    lit("empty_pp_code", key_code, 8'h33);
    pop1();

    // shift tracking; events drained continuously
    rd_en = 1'b1;
    send(8'h12);
    lit("shift_l_make", {7'd0, shift_held}, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h12);
    lit("fake_shift_brk", {7'd0, shift_held}, 8'h01);
    send(8'h59);
    send(8'hF0); send(8'h12);
    lit("shift_r_still", {7'd0, shift_held}, 8'h01);
    send(8'hF0); send(8'h59);
    lit("shift_released", {7'd0, shift_held}, 8'h00);
    send(8'hE0); send(8'h12);
    lit("fake_shift_make", {7'd0, shift_held}, 8'h00);
    tick();
    rd_en = 1'b0;

    // reset discards a dangling break prefix
    send(8'hF0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    lit("rst2_ovf", {7'd0, overflow}, 8'h00);
    send(8'h1C);
    lit("rst2_code", key_code, 8'h1C);
    lit("rst2_flags", {6'd0, key_extended, key_break}, 8'h00);
    pop1();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_event_decoder.md
Name: ps2_key_event_decoder

Overview:
Sits directly downstream of the PS/2 keyboard receiver. Consumes its raw Set-2 byte stream (scancode + single-cycle scan_ready pulse) and strips E0/F0 prefixes and the E1 Pause sequence. Emits one decoded key event per keystroke (code, make/break, extended) into a small show-ahead FIFO, and tracks shift-key state for the UI/console logic.

Parameters:
DEPTH, 4, event FIFO entries; power of two, ≥2
PAUSE_SKIP, 7, bytes discarded after an E1 prefix (rest of the Pause make sequence)

Ports:
CLK50MHZ  input  1  system clock; all logic on its rising edge
RST  input  1  synchronous reset, active-high
scancode  input  8  byte from receiver; valid only while scan_ready=1
scan_ready  input  1  one-cycle strobe: new byte on scancode
rd_en  input  1  consumer pop request; honoured only when event_valid=1
event_valid  output  1  FIFO not empty; head entry on key_* outputs
key_code  output  8  head entry: final (non-prefix) scancode byte
key_break  output  1  head entry: 1=release (F0 seen), 0=press
key_extended  output  1  head entry: 1=E0 prefix seen
shift_held  output  1  left (12h) or right (59h) shift currently pressed
overflow  output  1  sticky: an event was dropped because FIFO full

Behaviour:
- Reset (RST=1 at clock edge): prefix FSM→IDLE, skip counter=0, FIFO empty, event_valid=0, key_code=00h, key_break=0, key_extended=0, shift_held=0, overflow=0. Reset mid-sequence discards partial prefixes.
- Bytes are sampled only on cycles with scan_ready=1; all other cycles leave the FSM unchanged.
- Control bytes AAh, FAh, FEh, EEh, 00h, FFh: discarded in every state; FSM→IDLE; no event.
- FSM states and transitions, per sampled byte b:
  IDLE: E0h→EXT; F0h→BRK; E1h→SKIP (counter=PAUSE_SKIP); else emit {ext=0,brk=0,b}, stay IDLE.
  EXT: F0h→EXT_BRK; E0h→EXT (repeated prefix tolerated); E1h→SKIP; else emit {1,0,b}→IDLE.
  BRK: F0h→BRK; E0h→EXT_BRK; E1h→SKIP; else emit {0,1,b}→IDLE.
  EXT_BRK: E0h/F0h→EXT_BRK; E1h→SKIP; else emit {1,1,b}→IDLE.
  SKIP: every sampled byte, control bytes included, decrements the counter without being decoded; the byte that brings it to 0 returns the FSM to IDLE; no events.
- Emit = FIFO push of 10-bit entry {extended, break, code} on the cycle scan_ready=1. Latency: event_valid/key_* reflect the new entry on the cycle after scan_ready when FIFO was empty.
- FIFO show-ahead: key_* always show the head entry; with event_valid=0 they hold the last popped values (00h/0/0 after reset).
- Pop: rd_en=1 && event_valid=1 advances the head at the clock edge. rd_en while empty is ignored.
- Full (count=DEPTH): a push without a simultaneous pop is dropped and overflow is set to 1, held until RST. A push with a simultaneous pop succeeds, and count stays DEPTH.
- Empty with a simultaneous push and pop request: the pop is ignored (event_valid=0 that cycle) and the push lands.
- Pointers wrap modulo DEPTH; count range is 0..DEPTH.
- shift_held: updated on every emit with ext=0 and code 12h or 59h, independent of whether the FIFO accepted the entry. Separate left/right flags; make sets the flag, break clears it; shift_held = OR of both. E0-prefixed 12h (fake shift) does not affect shift state.

Test Plan:
- Byte 1Ch → next cycle event_valid=1, key_code=1Ch, break=0, ext=0; rd_en one cycle → event_valid=0.
- F0h,1Ch → one event {0,1,1Ch}; E0h,F0h,75h → one event {1,1,75h}; E0h,E0h,75h → {1,0,75h}.
- E1h,14h,77h,E1h,F0h,14h,F0h,77h then 1Ch → only event {0,0,1Ch}; AAh/FAh in IDLE → no event.
- DEPTH=4, no rd_en, five makes 15h..19h → 4 entries, overflow=1, pops return 15h,16h,17h,18h; overflow stays 1.
- FIFO full, push 1Ah with rd_en same cycle → count stays 4, overflow unchanged, 1Ah is read last.
- 12h → shift_held=1; 59h, then F0h,12h → still 1; F0h,59h → 0; E0h,12h → unchanged. RST asserted after a lone F0h → next byte 1Ch decodes as make.
